cache_ctrl_refill: RTL

//  Downstream consumer of the cache controller pipeline output (dvld/drdy, hit, data, addr, web, way web).

---
 rtl/cache_ctrl_refill.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl_refill.sv
// cache_ctrl_refill: back end of the cache controller pipeline.
// Serves read hits directly, writes every store through to memory (and to
// the data SRAM on a hit), and refills a round-robin victim way on a read
// miss before returning the requested word.
// Ports:
//   clk, reset (sync, active-low)
//   p*_i / prdy_o      : request from the tag/data lookup pipeline
//   rvld_o/rrdy_i/rdat_o : response to the requester
//   mreq_* / mresp_*   : single memory request channel and read-beat return
//   sram_* / tag_*     : data and tag SRAM write ports (per-way active-low web)
module cache_ctrl_refill #(
  parameter int unsigned ADDR_WIDTH          = 32,
  parameter int unsigned CLINE_SIZE_WORD     = 4,
  parameter int unsigned CLINE_ADDR_WIDTH    = 7,
  parameter int unsigned CLINE_WORD_WIDTH    = 32,
  parameter int unsigned TAG_SRAM_DATA_WIDTH = 32,
  parameter int unsigned NUM_WAYS            = 4,
  parameter int unsigned WMASK_WIDTH         = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   pvld_i,
  output logic                                   prdy_o,
  input  logic                                   phit_i,
  input  logic [CLINE_WORD_WIDTH-1:0]            pddat_i,
  input  logic [ADDR_WIDTH-1:0]                  paddr_i,
  input  logic                                   pweb_i,
  input  logic [NUM_WAYS-1:0]                    pcache_web_i,
  input  logic [WMASK_WIDTH-1:0]                 pwmask_i,
  input  logic [CLINE_WORD_WIDTH-1:0]            pwdat_i,
  output logic                                   rvld_o,
  input  logic                                   rrdy_i,
  output logic [CLINE_WORD_WIDTH-1:0]            rdat_o,
  output logic                                   mreq_vld_o,
  input  logic                                   mreq_rdy_i,
  output logic                                   mreq_we_o,
  output logic [ADDR_WIDTH-1:0]                  maddr_o,
  output logic [CLINE_WORD_WIDTH-1:0]            mwdat_o,
  output logic [WMASK_WIDTH-1:0]                 mwmask_o,
  input  logic                                   mresp_vld_i,
  input  logic [CLINE_WORD_WIDTH-1:0]            mresp_dat_i,
  output logic [NUM_WAYS-1:0]                    sram_web_o,
  output logic [CLINE_ADDR_WIDTH+$clog2(CLINE_SIZE_WORD)-1:0] sram_addr_o,
  output logic [CLINE_WORD_WIDTH-1:0]            sram_wdat_o,
  output logic [WMASK_WIDTH-1:0]                 sram_wmask_o,
  output logic [NUM_WAYS-1:0]                    tag_web_o,
  output logic [CLINE_ADDR_WIDTH-1:0]            tag_addr_o,
  output logic [TAG_SRAM_DATA_WIDTH-1:0]         tag_wdat_o
);

  localparam int unsigned OFS   = $clog2(CLINE_SIZE_WORD);
  localparam int unsigned BOFS  = $clog2(WMASK_WIDTH);
  localparam int unsigned IDX   = CLINE_ADDR_WIDTH;
  localparam int unsigned DW    = CLINE_WORD_WIDTH;
  localparam int unsigned TW    = TAG_SRAM_DATA_WIDTH;
  localparam int unsigned LW    = ADDR_WIDTH - BOFS - OFS;
  localparam int unsigned TPADW = TW - 1;
  localparam int unsigned SAW   = IDX + OFS;
  localparam int unsigned LOW   = BOFS + OFS;

  typedef enum logic [2:0] {
    S_IDLE, S_INV, S_RD_REQ, S_FILL, S_TAG, S_WR, S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         line_q, line_d;
  logic [OFS-1:0]        woff_q, woff_d;
  logic [OFS-1:0]        beat_q, beat_d;
  logic [NUM_WAYS-1:0]   victim_q, victim_d;

  logic                  prdy_q, prdy_d;
  logic                  rvld_q, rvld_d;
  logic [DW-1:0]         rdat_q, rdat_d;
  logic                  mreq_vld_q, mreq_vld_d;
  logic                  mreq_we_q, mreq_we_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DW-1:0]         mwdat_q, mwdat_d;
  logic [WMASK_WIDTH-1:0] mwmask_q, mwmask_d;
  logic [NUM_WAYS-1:0]   sram_web_q, sram_web_d;
  logic [SAW-1:0]        sram_addr_q, sram_addr_d;
  logic [DW-1:0]         sram_wdat_q, sram_wdat_d;
  logic [WMASK_WIDTH-1:0] sram_wmask_q, sram_wmask_d;
  logic [NUM_WAYS-1:0]   tag_web_q, tag_web_d;
  logic [IDX-1:0]        tag_addr_q, tag_addr_d;
  logic [TW-1:0]         tag_wdat_q, tag_wdat_d;

  logic [IDX-1:0]        idx_c;
  logic [LW-IDX-1:0]     tag_c;

  assign idx_c = line_q[IDX-1:0];
  assign tag_c = line_q[LW-1:IDX];

  // Next state and next registered outputs; every output is a flop so all
  // values here are what the ports show in the following cycle.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    woff_d       = woff_q;
    beat_d       = beat_q;
    victim_d     = victim_q;
    rvld_d       = rvld_q;
    rdat_d       = rdat_q;
    mreq_vld_d   = mreq_vld_q;
    mreq_we_d    = mreq_we_q;
    maddr_d      = maddr_q;
    mwdat_d      = mwdat_q;
    mwmask_d     = mwmask_q;
    sram_web_d   = '1;
    sram_addr_d  = sram_addr_q;
    sram_wdat_d  = sram_wdat_q;
    sram_wmask_d = sram_wmask_q;
    tag_web_d    = '1;
    tag_addr_d   = tag_addr_q;
    tag_wdat_d   = tag_wdat_q;

    unique case (state_q)
      S_IDLE: begin
        if (pvld_i) begin
          line_d = paddr_i[ADDR_WIDTH-1:LOW];
          woff_d = paddr_i[LOW-1:BOFS];
          if (!pweb_i) begin
            // Write-through for both hit and miss; SRAM updated on hit only.
            state_d      = S_WR;
            mreq_vld_d   = 1'b1;
            mreq_we_d    = 1'b1;
            maddr_d      = paddr_i;
            mwdat_d      = pwdat_i;
            mwmask_d     = pwmask_i;
            sram_addr_d  = paddr_i[LOW+IDX-1:BOFS];
            sram_wdat_d  = pwdat_i;
            sram_wmask_d = pwmask_i;
            if (phit_i) sram_web_d = pcache_web_i;
          end else if (phit_i) begin
            state_d = S_RESP;
            rvld_d  = 1'b1;
            rdat_d  = pddat_i;
          end else begin
            // Invalidate the victim first so an aborted fill never looks valid.
            state_d    = S_INV;
            tag_web_d  = ~victim_q;
            tag_addr_d = paddr_i[LOW+IDX-1:LOW];
            tag_wdat_d = '0;
          end
        end
      end

      S_INV: begin
        state_d    = S_RD_REQ;
        mreq_vld_d = 1'b1;
        mreq_we_d  = 1'b0;
        maddr_d    = {line_q, {LOW{1'b0}}};
      end

      S_RD_REQ: begin
        if (mreq_rdy_i) begin
          state_d    = S_FILL;
          mreq_vld_d = 1'b0;
          beat_d     = '0;
        end
      end

      S_FILL: begin
        if (mresp_vld_i) begin
          sram_web_d   = ~victim_q;
          sram_addr_d  = {idx_c, beat_q};
          sram_wdat_d  = mresp_dat_i;
          sram_wmask_d = '1;
          beat_d       = beat_q + OFS'(1);
          if (beat_q == woff_q) rdat_d = mresp_dat_i;
          if (beat_q == OFS'(CLINE_SIZE_WORD - 1)) begin
            state_d    = S_TAG;
            tag_web_d  = ~victim_q;
            tag_addr_d = idx_c;
            tag_wdat_d = {1'b1, TPADW'(tag_c)};
          end
        end
      end

      S_TAG: begin
        state_d  = S_RESP;
        rvld_d   = 1'b1;
        victim_d = {victim_q[NUM_WAYS-2:0], victim_q[NUM_WAYS-1]};
      end

      S_WR: begin
        if (mreq_rdy_i) begin
          state_d    = S_RESP;
          mreq_vld_d = 1'b0;
          rvld_d     = 1'b1;
          rdat_d     = '0;
        end
      end

      S_RESP: begin
        if (rrdy_i) begin
          state_d = S_IDLE;
          rvld_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    prdy_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      woff_q       <= '0;
      beat_q       <= '0;
      victim_q     <= NUM_WAYS'(1);
      prdy_q       <= 1'b1;
      rvld_q       <= 1'b0;
      rdat_q       <= '0;
      mreq_vld_q   <= 1'b0;
      mreq_we_q    <= 1'b0;
      maddr_q      <= '0;
      mwdat_q      <= '0;
      mwmask_q     <= '0;
      sram_web_q   <= '1;
      sram_addr_q  <= '0;
      sram_wdat_q  <= '0;
      sram_wmask_q <= '0;
      tag_web_q    <= '1;
      tag_addr_q   <= '0;
      tag_wdat_q   <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      woff_q       <= woff_d;
      beat_q       <= beat_d;
      victim_q     <= victim_d;
      prdy_q       <= prdy_d;
      rvld_q       <= rvld_d;
      rdat_q       <= rdat_d;
      mreq_vld_q   <= mreq_vld_d;
      mreq_we_q    <= mreq_we_d;
      maddr_q      <= maddr_d;
      mwdat_q      <= mwdat_d;
      mwmask_q     <= mwmask_d;
      sram_web_q   <= sram_web_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdat_q  <= sram_wdat_d;
      sram_wmask_q <= sram_wmask_d;
      tag_web_q    <= tag_web_d;
      tag_addr_q   <= tag_addr_d;
      tag_wdat_q   <= tag_wdat_d;
    end
  end

  assign prdy_o       = prdy_q;
  assign rvld_o       = rvld_q;
  assign rdat_o       = rdat_q;
  assign mreq_vld_o   = mreq_vld_q;
  assign mreq_we_o    = mreq_we_q;
  assign maddr_o      = maddr_q;
  assign mwdat_o      = mwdat_q;
  assign mwmask_o     = mwmask_q;
  assign sram_web_o   = sram_web_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wdat_o  = sram_wdat_q;
  assign sram_wmask_o = sram_wmask_q;
  assign tag_web_o    = tag_web_q;
  assign tag_addr_o   = tag_addr_q;
  assign tag_wdat_o   = tag_wdat_q;

endmodule
